uart_transmitter: RTL and testbench
===================================

# uart_transmitter

UART serial transmitter that feeds the UART receiver's serial `in` line. It accepts bytes from the parallel side through a 4-entry FIFO. Each byte goes out as an 11-bit frame: start bit, 8 data bits LSB first, odd parity bit, one stop bit. Bit timing matches the receiver's sampling: 8 ticks per bit, one tick every 5 clocks, so 40 clocks per bit.

## Interface
- `CLKS_PER_TICK`, 5, clocks per sample tick; tick fires when the tick counter equals this value.
- `TICKS_PER_BIT`, 8, ticks per serial bit.
- `FIFO_DEPTH`, 4, input FIFO entries; must be a power of 2.
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-low; asserted while 0.
- `data_in` input 8: byte to queue.
- `wr_en` input 1: write strobe; sampled on the rising edge.
- `full` output 1: FIFO holds `FIFO_DEPTH` entries.
- `empty` output 1: FIFO holds 0 entries.
- `tx` output 1: serial line, registered; idles high.
- `busy` output 1: high whenever the FSM is not IDLE.
- `done` output 1: one-cycle pulse after a stop bit completes.
- `overflow` output 1: one-cycle pulse when a write is dropped.

## Operation
- Reset values: `tx`=1, `busy`=0, `done`=0, `overflow`=0, `full`=0, `empty`=1. Reset also clears FSM to IDLE, FIFO pointers/count, tick/bit counters and shift register.
- Reset is asynchronous: asserting it mid-frame drives `tx` high immediately and discards the frame and all queued bytes.
- FIFO write: `wr_en`=1 and `full`=0 before the edge stores `data_in`.
  - `wr_en`=1 with `full`=1 drops the byte, leaves contents unchanged, and pulses `overflow` for one cycle.
  - Simultaneous write and pop with the FIFO not full leaves the count unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
- Tick generator: counts 1..`CLKS_PER_TICK`, ticks on the last count, and restarts at 1 on every frame start. This makes each bit exactly `CLKS_PER_TICK*TICKS_PER_BIT` clocks long.
- Parity: `~^data`, computed when the byte is popped, so frame ones (data + parity) are odd.
- FSM states:
  - IDLE: `tx`=1. If `empty`=0, pop the head into the shift register, drive `tx`=0 and go to START.
  - START: hold `tx`=0 for one bit, then go to DATA with `tx`=bit0.
  - DATA: shift right each bit period and output LSB; bit index 0..7. After bit7's period, go to PARITY.
  - PARITY: output the parity bit for one bit, then go to STOP.
  - STOP: `tx`=1 for one bit. At the end, pulse `done`. If `empty`=0, pop and go directly to START (no idle gap); otherwise go to IDLE.
- A new byte written while a frame is in progress waits in the FIFO; the current frame is never altered.

## Timing
- Write into an empty FIFO while IDLE at edge k: `empty`=0 after edge k; pop occurs and `tx` falls after edge k+1.
- Frame length is 11 bits = 440 clocks at defaults. `tx` segments begin at edge k+1+40n for n=0..10.
- `done` is high for the single cycle after edge k+441. The same edge starts the next frame if the FIFO is non-empty.
- `busy` rises with `tx`'s first fall. It stays high across back-to-back frames and falls at the edge where STOP ends with the FIFO empty.
- `full`/`empty` reflect the FIFO count after each edge; no combinational path from `wr_en` to `full`.

## Test plan
- Write 0xA5 once while idle -> `tx` high for 1 cycle after the write, then 40-clock segments 0,1,0,1,0,0,1,0,1,1(parity),1(stop); `done` pulses once at +441.
- Write 0x07 -> data 1,1,1,0,0,0,0,0, parity 0; a receiver instance on `tx` reports `data_out`=0x07 with `load`=0.
- Write 0x11, 0x22, 0x33 on consecutive cycles -> three frames back-to-back, 1320 clocks of activity; `busy` stays high throughout; three `done` pulses 440 clocks apart.
- Write 6 bytes 0x01..0x06 on consecutive cycles from idle:
  - 0x01 pops at edge 1; `full`=1 after edge 4.
  - 0x06 is dropped with a one-cycle `overflow` pulse.
  - Exactly 0x01..0x05 are transmitted in order.
- Assert `reset`=0 mid-DATA of a frame with 2 bytes queued -> `tx`=1 and `busy`=0 immediately; `empty`=1; no further frames after release.
- Idle with no writes for 1000 clocks -> `tx` constant 1; `done` and `overflow` never assert.

Source files
------------

// File: rtl/uart_transmitter_if.sv
// -----------------------------------------------------------------------------
// uart_transmitter_if
//
// Parallel-side bundle of the UART transmitter: the byte write strobe plus the
// FIFO status flags that the producer watches.
//
//   data_in  : byte to queue (producer -> transmitter)
//   wr_en    : write strobe, sampled on the rising clock edge
//   full     : FIFO holds FIFO_DEPTH entries (registered)
//   empty    : FIFO holds no entries (registered)
//   overflow : one-cycle pulse when a write was dropped because the FIFO was full
//
// master : the producer that writes bytes
// slave  : the transmitter
// -----------------------------------------------------------------------------
interface uart_transmitter_if;
  logic [7:0] data_in;
  logic       wr_en;
  logic       full;
  logic       empty;
  logic       overflow;

  modport master (
    output data_in,
    output wr_en,
    input  full,
    input  empty,
    input  overflow
  );

  modport slave (
    input  data_in,
    input  wr_en,
    output full,
    output empty,
    output overflow
  );
endinterface

// File: rtl/uart_transmitter.sv
// -----------------------------------------------------------------------------
// uart_transmitter
//
// Serial transmitter feeding a UART receiver. Bytes enter through a small FIFO
// and leave as 11-bit frames: start (0), 8 data bits LSB first, odd parity,
// one stop bit (1). Each bit lasts CLKS_PER_TICK * TICKS_PER_BIT clocks so the
// timing lines up with the receiver's tick-based sampling.
//
// Parameters
//   CLKS_PER_TICK : clocks per sample tick (tick fires on the last count)
//   TICKS_PER_BIT : sample ticks per serial bit
//   FIFO_DEPTH    : input FIFO entries, must be a power of 2
//
// Ports
//   clk   : single clock, rising-edge
//   reset : asynchronous, active-low
//   bus   : parallel write side (data_in, wr_en, full, empty, overflow)
//   tx    : serial line, registered, idles high
//   busy  : high whenever the frame FSM is not idle
//   done  : one-cycle pulse after a stop bit completes
// -----------------------------------------------------------------------------
module uart_transmitter #(
  parameter int CLKS_PER_TICK = 5,
  parameter int TICKS_PER_BIT = 8,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic              clk,
  input  logic              reset,
  uart_transmitter_if.slave bus,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int TCK_W = $clog2(CLKS_PER_TICK + 1);
  localparam int TIX_W = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  // ---------------------------------------------------------------------------
  // Input FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic [7:0]       head;

  // Flags come straight from the registered count, so wr_en never reaches
  // full/empty combinationally.
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push       = bus.wr_en && !fifo_full;
  assign head       = mem_q[rd_ptr_q];

  // NOTE: the storage array has no reset; the pointers and count alone decide
  // which entries are valid, so clearing the data itself buys nothing.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.data_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      // Power-of-2 depth lets the pointers wrap by natural overflow.
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      // A write against a full FIFO is dropped; flag it for one cycle.
      overflow_q <= bus.wr_en && fifo_full;
    end
  end

  assign bus.full     = fifo_full;
  assign bus.empty    = fifo_empty;
  assign bus.overflow = overflow_q;

  // ---------------------------------------------------------------------------
  // Bit timing and frame FSM
  // ---------------------------------------------------------------------------
  state_e           state_q,    state_d;
  logic [TCK_W-1:0] clk_cnt_q,  clk_cnt_d;
  logic [TIX_W-1:0] tick_idx_q, tick_idx_d;
  logic [2:0]       bit_idx_q,  bit_idx_d;
  logic [7:0]       shift_q,    shift_d;
  logic             parity_q,   parity_d;
  logic             tx_q,       tx_d;
  logic             done_q,     done_d;
  logic             tick;
  logic             bit_end;
  logic             start_frame;

  // clk_cnt runs 1..CLKS_PER_TICK; the tick is the last count. bit_end marks
  // the final tick of a bit, i.e. the edge where the next bit goes out.
  assign tick    = (clk_cnt_q == TCK_W'(CLKS_PER_TICK));
  assign bit_end = tick && (tick_idx_q == TIX_W'(TICKS_PER_BIT - 1));

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    tick_idx_d  = tick_idx_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    tx_d        = tx_q;
    done_d      = 1'b0;
    start_frame = 1'b0;

    if (state_q != S_IDLE) begin
      if (tick) begin
        clk_cnt_d  = TCK_W'(1);
        tick_idx_d = bit_end ? '0 : tick_idx_q + TIX_W'(1);
      end else begin
        clk_cnt_d  = clk_cnt_q + TCK_W'(1);
      end
    end

    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) start_frame = 1'b1;
      end

      S_START: begin
        if (bit_end) begin
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            tx_d    = parity_q;
            state_d = S_PARITY;
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end

      S_PARITY: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
      end

      S_STOP: begin
        if (bit_end) begin
          done_d = 1'b1;
          // Chain straight into the next frame when a byte is waiting.
          if (!fifo_empty) begin
            start_frame = 1'b1;
          end else begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase

    // Frame start: pop the head, latch its parity, drive the start bit and
    // realign the tick generator so every bit is exactly one period long.
    if (start_frame) begin
      shift_d    = head;
      parity_d   = ~^head;
      tx_d       = 1'b0;
      state_d    = S_START;
      clk_cnt_d  = TCK_W'(1);
      tick_idx_d = '0;
    end
  end

  assign pop = start_frame;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      clk_cnt_q  <= '0;
      tick_idx_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      tick_idx_q <= tick_idx_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != S_IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// -----------------------------------------------------------------------------
// tb_uart_transmitter
//
// Directed bench for uart_transmitter at default parameters (40 clocks/bit,
// 440 clocks/frame). Frames are checked at the first and last clock of each
// bit segment, sampled mid-bit and reassembled into a byte, and the done /
// overflow pulses are counted on the falling edge.
// -----------------------------------------------------------------------------
module tb_uart_transmitter;

  logic clk = 1'b0;
  logic reset;
  logic tx;
  logic busy;
  logic done;

  int n_vec    = 0;
  int n_miss   = 0;
  int done_cnt = 0;
  int ovf_cnt  = 0;
  int d0;
  int o0;
  int tx_low;
  int busy_hi;

  uart_transmitter_if bus ();

  uart_transmitter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .tx    (tx),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done)         done_cnt++;
    if (bus.overflow) ovf_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and land 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after edge s+skip, where edge s drove the start bit. Walks the
  // 440-clock frame and returns just after edge s+440 (the done edge).
  task automatic check_frame(input logic [7:0] data, input logic par,
                             input bit more, input int skip, input string tag);
    logic [10:0] exp_bits;
    logic [10:0] rx_bits;
    int          seg;
    int          pos;
    exp_bits = {1'b1, par, data, 1'b0};
    rx_bits  = '0;
    for (int c = skip; c < 440; c++) begin
      seg = c / 40;
      pos = c % 40;
      if (pos == 0 || pos == 39)
        check($sformatf("%s tx seg%0d pos%0d", tag, seg, pos), tx, exp_bits[seg]);
      if (pos == 20) begin
        rx_bits[seg] = tx;
        check($sformatf("%s busy seg%0d", tag, seg), busy, 1);
      end
      if (c == 439) check($sformatf("%s done early", tag), done, 0);
      step(1);
    end
    check($sformatf("%s done pulse", tag), done, 1);
    check($sformatf("%s rx data", tag), rx_bits[8:1], data);
    check($sformatf("%s rx odd ones", tag), ^rx_bits[9:1], 1);
    check($sformatf("%s rx start/stop", tag), {rx_bits[10], rx_bits[0]}, 2'b10);
    check($sformatf("%s tx after", tag), tx, more ? 0 : 1);
    check($sformatf("%s busy after", tag), busy, more ? 1 : 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset       = 1'b0;
    bus.wr_en   = 1'b0;
    bus.data_in = 8'h00;
    @(posedge clk);
    #1;
    step(3);

    // Reset state
    check("rst tx", tx, 1);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst overflow", bus.overflow, 0);
    check("rst full", bus.full, 0);
    check("rst empty", bus.empty, 1);
    reset = 1'b1;
    step(2);
    check("idle tx", tx, 1);

    // Single byte 0xA5: start, 1,0,1,0,0,1,0,1, parity 1, stop
    d0 = done_cnt;
    bus.data_in = 8'hA5;
    bus.wr_en   = 1'b1;
    step(1);
    bus.wr_en   = 1'b0;
    check("a5 empty k", bus.empty, 0);
    check("a5 tx k", tx, 1);
    check("a5 busy k", busy, 0);
    step(1);
    check("a5 empty k+1", bus.empty, 1);
    check_frame(8'hA5, 1'b1, 1'b0, 0, "a5");
    step(1);
    check("a5 done off", done, 0);
    check("a5 done count", done_cnt - d0, 1);

    // Single byte 0x07: data 1,1,1,0,0,0,0,0, parity 0
    bus.data_in = 8'h07;
    bus.wr_en   = 1'b1;
    step(1);
    bus.wr_en   = 1'b0;
    step(1);
    check_frame(8'h07, 1'b0, 1'b0, 0, "x07");
    step(1);

    // Three bytes back-to-back
    d0 = done_cnt;
    bus.wr_en   = 1'b1;
    bus.data_in = 8'h11;
    step(1);
    bus.data_in = 8'h22;
    step(1);
    check("burst tx fall", tx, 0);
    bus.data_in = 8'h33;
    step(1);
    bus.wr_en   = 1'b0;
    check("burst empty", bus.empty, 0);
    check_frame(8'h11, 1'b1, 1'b1, 1, "b11");
    check_frame(8'h22, 1'b1, 1'b1, 0, "b22");
    check_frame(8'h33, 1'b1, 1'b0, 0, "b33");
    step(1);
    check("burst done count", done_cnt - d0, 3);

    // Six bytes: fill, overflow on the sixth
    d0 = done_cnt;
    o0 = ovf_cnt;
    for (int i = 0; i < 6; i++) begin
      bus.data_in = 8'(i + 1);
      bus.wr_en   = 1'b1;
      step(1);
      if (i == 0) begin
        check("six empty k", bus.empty, 0);
        check("six full k", bus.full, 0);
      end
      if (i == 1) check("six tx fall", tx, 0);
      if (i == 3) check("six full k+3", bus.full, 0);
      if (i == 4) begin
        check("six full k+4", bus.full, 1);
        check("six ovf k+4", bus.overflow, 0);
      end
      if (i == 5) begin
        check("six ovf k+5", bus.overflow, 1);
        check("six full k+5", bus.full, 1);
      end
    end
    bus.wr_en = 1'b0;
    step(1);
    check("six ovf k+6", bus.overflow, 0);
    check("six full k+6", bus.full, 1);
    check_frame(8'h01, 1'b0, 1'b1, 5, "f01");
    check("six full after pop", bus.full, 0);
    check_frame(8'h02, 1'b0, 1'b1, 0, "f02");
    check_frame(8'h03, 1'b1, 1'b1, 0, "f03");
    check_frame(8'h04, 1'b0, 1'b1, 0, "f04");
    check_frame(8'h05, 1'b1, 1'b0, 0, "f05");
    check("six empty end", bus.empty, 1);
    step(1);
    check("six ovf count", ovf_cnt - o0, 1);
    check("six done count", done_cnt - d0, 5);

    // Reset mid-DATA with two bytes queued
    bus.wr_en   = 1'b1;
    bus.data_in = 8'h5A;
    step(1);
    bus.data_in = 8'hC3;
    step(1);
    bus.data_in = 8'h3C;
    step(1);
    bus.wr_en   = 1'b0;
    check("rq empty", bus.empty, 0);
    d0 = done_cnt;
    step(100);
    check("rq busy mid", busy, 1);
    #2;
    reset = 1'b0;
    #1;
    check("rq tx async", tx, 1);
    check("rq busy async", busy, 0);
    check("rq empty async", bus.empty, 1);
    check("rq full async", bus.full, 0);
    step(3);
    reset   = 1'b1;
    tx_low  = 0;
    busy_hi = 0;
    for (int i = 0; i < 600; i++) begin
      step(1);
      if (tx !== 1'b1)  tx_low++;
      if (busy !== 1'b0) busy_hi++;
    end
    check("rq no tx activity", tx_low, 0);
    check("rq no busy", busy_hi, 0);
    check("rq no done", done_cnt - d0, 0);
    check("rq empty after", bus.empty, 1);

    // Long idle
    d0     = done_cnt;
    o0     = ovf_cnt;
    tx_low = 0;
    for (int i = 0; i < 1000; i++) begin
      step(1);
      if (tx !== 1'b1) tx_low++;
    end
    check("idle tx constant", tx_low, 0);
    check("idle no done", done_cnt - d0, 0);
    check("idle no overflow", ovf_cnt - o0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
